// File: rtl/io_pkg.sv
// Shared constants for the io_irq_timer peripheral: register offsets,
// CTRL bit positions and the default register window base.
package io_pkg;

   localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hBFF8;

   localparam logic [2:0] REG_TLO  = 3'd0;
   localparam logic [2:0] REG_THI  = 3'd1;
   localparam logic [2:0] REG_CTRL = 3'd2;
   localparam logic [2:0] REG_STAT = 3'd3;
   localparam logic [2:0] REG_PORT = 3'd4;

   localparam int CTRL_RUN     = 0;
   localparam int CTRL_FREERUN = 1;
   localparam int CTRL_IEN     = 2;
   localparam int CTRL_TO_NMI  = 3;

   // Field order matches the CTRL bit indices above (run is bit 0).
   typedef struct packed {
      logic toNmi;
      logic ien;
      logic freerun;
      logic run;
   } ctrl_t;

endpackage

// File: rtl/io_prescaler.sv
// Timer prescaler: divides clk by PRESCALE while enabled, emitting a
// single-cycle tick on the wrap; the count is held at 0 while disabled.
module io_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_count;

   assign o_tick = i_en && (r_count == LAST);

   always_ff @(posedge clk) begin
      if (reset || !i_en) begin
         r_count <= '0;
      end else if (o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/io_irq_timer.sv
// Memory-mapped I/O port plus 16-bit interval timer driving CPU irq/nmi.
// Optional coherent 16-bit counter reads: define IO_IRQ_TIMER_SNAPSHOT_EN.
module io_irq_timer
   import io_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  data_i,
   input  logic        write,
   output logic [7:0]  data_o,
   output logic        sel,
   output logic        irq,
   output logic        nmi,
   output logic [7:0]  port_out
);

   logic [15:0] r_counter;
   logic [7:0]  r_latch_lo;
   logic [7:0]  r_latch_hi;
   ctrl_t       r_ctrl;
   logic        r_flag;
   logic [7:0]  r_port;

   logic [2:0]  w_offset;
   logic        w_we;
   logic        w_thi_wr;
   logic        w_stat_clr;
   logic        w_tick;
   logic        w_expire;
   logic        w_timer_int;
   logic [7:0]  w_thi_rd;
   logic [7:0]  w_rdata;

   assign sel        = (address[15:3] == BASE_ADDR[15:3]);
   assign w_offset   = address[2:0];
   assign w_we       = sel && write;
   assign w_thi_wr   = w_we && (w_offset == REG_THI);
   assign w_stat_clr = w_we && (w_offset == REG_STAT) && data_i[0];
   assign w_expire   = w_tick && (r_counter == 16'h0000);

   io_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .i_en  (r_ctrl.run),
      .o_tick(w_tick)
   );

   // A THI load overrides a coincident tick, but an expiry on that tick
   // still sets FLAG, and setting FLAG always beats any clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_counter  <= '0;
         r_latch_lo <= '0;
         r_latch_hi <= '0;
         r_ctrl     <= '0;
         r_flag     <= 1'b0;
         r_port     <= '0;
      end else begin
         if (w_we && (w_offset == REG_TLO)) begin
            r_latch_lo <= data_i;
         end

         if (w_thi_wr) begin
            r_latch_hi <= data_i;
            r_counter  <= {data_i, r_latch_lo};
         end else if (w_tick) begin
            if (r_counter != 16'h0000) begin
               r_counter <= r_counter - 16'd1;
            end else if (r_ctrl.freerun) begin
               r_counter <= {r_latch_hi, r_latch_lo};
            end
         end

         if (w_we && (w_offset == REG_CTRL)) begin
            r_ctrl <= ctrl_t'(data_i[3:0]);
         end else if (w_expire && !r_ctrl.freerun && !w_thi_wr) begin
            r_ctrl.run <= 1'b0;
         end

         if (w_expire) begin
            r_flag <= 1'b1;
         end else if (w_thi_wr || w_stat_clr) begin
            r_flag <= 1'b0;
         end

         if (w_we && (w_offset == REG_PORT)) begin
            r_port <= data_i;
         end
      end
   end

`ifdef IO_IRQ_TIMER_SNAPSHOT_EN
   logic [7:0] r_snap_hi;

   // Reading TLO freezes the high byte so a following THI read matches it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap_hi <= '0;
      end else if (sel && !write && (w_offset == REG_TLO)) begin
         r_snap_hi <= r_counter[15:8];
      end
   end

   assign w_thi_rd = r_snap_hi;
`else
   assign w_thi_rd = r_counter[15:8];
`endif

   always_comb begin
      w_rdata = 8'h00;
      case (w_offset)
         REG_TLO:  w_rdata = r_counter[7:0];
         REG_THI:  w_rdata = w_thi_rd;
         REG_CTRL: w_rdata = {4'h0, r_ctrl};
         REG_STAT: w_rdata = {7'h00, r_flag};
         REG_PORT: w_rdata = r_port;
         default:  w_rdata = 8'h00;
      endcase
   end

   assign data_o      = sel ? w_rdata : 8'h00;
   assign w_timer_int = r_flag && r_ctrl.ien;
   assign irq         = r_port[0] | (w_timer_int & ~r_ctrl.toNmi);
   assign nmi         = r_port[1] | (w_timer_int & r_ctrl.toNmi);
   assign port_out    = r_port;

endmodule
